// File: rtl/mc_sequencer_if.sv
// Control bundle between the multi-cycle sequencer and the IR/decoder and PC/RF/memory enables.
// master = sequencer side, slave = datapath/decoder side.
interface mc_sequencer_if #(
  parameter int CNT_W = 32
);
  logic [6:0]       opcode;
  logic [2:0]       funct3;
  logic             br_taken;
  logic             halt_req;
  logic             mem_rdy;
  logic [2:0]       state;
  logic             i_mem_req;
  logic             ir_we;
  logic             pc_we;
  logic [1:0]       pc_src;
  logic             rf_we_en;
  logic             d_mem_req;
  logic             d_mem_wr;
  logic             retire;
  logic [CNT_W-1:0] num_inst;
  logic             halt;
  logic             err;

  modport master (
    input  opcode, funct3, br_taken, halt_req, mem_rdy,
    output state, i_mem_req, ir_we, pc_we, pc_src, rf_we_en,
           d_mem_req, d_mem_wr, retire, num_inst, halt, err
  );

  modport slave (
    output opcode, funct3, br_taken, halt_req, mem_rdy,
    input  state, i_mem_req, ir_we, pc_we, pc_src, rf_we_en,
           d_mem_req, d_mem_wr, retire, num_inst, halt, err
  );
endinterface

// File: rtl/mc_sequencer.sv
// RV32I multi-cycle sequencer: IF/ID/EX/MEM/WB stepping, write-strobe gating, next-PC select,
// MEM stretch with timeout halt, retired-instruction counter. Strobes decode from the state register.
module mc_sequencer #(
  parameter int CNT_W        = 32,
  parameter int MEM_WAIT_MAX = 15
) (
  input  logic          clk_i,
  input  logic          rst_i,
  mc_sequencer_if.master bus
);

  typedef enum logic [2:0] {
    S_IF  = 3'd0,
    S_ID  = 3'd1,
    S_EX  = 3'd2,
    S_MEM = 3'd3,
    S_WB  = 3'd4,
    S_HLT = 3'd5
  } state_e;

  localparam logic [6:0] OP_BR   = 7'b1100011;
  localparam logic [6:0] OP_LD   = 7'b0000011;
  localparam logic [6:0] OP_ST   = 7'b0100011;
  localparam logic [6:0] OP_JAL  = 7'b1101111;
  localparam logic [6:0] OP_JALR = 7'b1100111;
  localparam logic [7:0] WAIT_LIMIT = 8'(MEM_WAIT_MAX);

  state_e           state_q;
  logic [7:0]       wait_q;
  logic [7:0]       wait_d;
  logic [CNT_W-1:0] num_q;
  logic             err_q;

  logic is_br, is_ld, is_st, is_jal, is_jalr, is_alu, is_ill;
  logic unused_funct3;

  assign unused_funct3 = ^bus.funct3;

  always_comb begin
    is_br   = (bus.opcode == OP_BR);
    is_ld   = (bus.opcode == OP_LD);
    is_st   = (bus.opcode == OP_ST);
    is_jal  = (bus.opcode == OP_JAL);
    is_jalr = (bus.opcode == OP_JALR);
    is_alu  = (bus.opcode == 7'b0110011) || (bus.opcode == 7'b0010011) ||
              (bus.opcode == 7'b0110111) || (bus.opcode == 7'b0010111);
    is_ill  = !(is_br || is_ld || is_st || is_jal || is_jalr || is_alu);
  end

  // Strobes are gated off by reset combinationally so an in-flight access is abandoned at once.
  always_comb begin
    bus.i_mem_req = 1'b0;
    bus.ir_we     = 1'b0;
    bus.pc_we     = 1'b0;
    bus.pc_src    = 2'd0;
    bus.rf_we_en  = 1'b0;
    bus.d_mem_req = 1'b0;
    bus.d_mem_wr  = 1'b0;
    bus.retire    = 1'b0;
    if (!rst_i) begin
      case (state_q)
        S_IF: begin
          bus.i_mem_req = 1'b1;
          bus.ir_we     = 1'b1;
        end
        S_EX: begin
          if (is_br) begin
            bus.pc_we  = 1'b1;
            bus.retire = 1'b1;
            bus.pc_src = bus.br_taken ? 2'd1 : 2'd0;
          end else if (is_ill) begin
            bus.pc_we  = 1'b1;
            bus.retire = 1'b1;
          end
        end
        S_MEM: begin
          bus.d_mem_req = 1'b1;
          bus.d_mem_wr  = is_st;
          if (bus.mem_rdy && is_st) begin
            bus.pc_we  = 1'b1;
            bus.retire = 1'b1;
          end
        end
        S_WB: begin
          bus.rf_we_en = 1'b1;
          bus.pc_we    = 1'b1;
          bus.retire   = 1'b1;
          bus.pc_src   = is_jal ? 2'd1 : (is_jalr ? 2'd2 : 2'd0);
        end
        default: ;
      endcase
    end
  end

  assign wait_d = wait_q + 8'd1;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= S_IF;
      wait_q  <= 8'd0;
      num_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      if (bus.retire) num_q <= num_q + CNT_W'(1);
      case (state_q)
        S_IF: state_q <= S_ID;
        S_ID: state_q <= bus.halt_req ? S_HLT : S_EX;
        S_EX: begin
          if (is_br || is_ill) begin
            state_q <= S_IF;
          end else if (is_ld || is_st) begin
            state_q <= S_MEM;
            wait_q  <= 8'd0;
          end else begin
            state_q <= S_WB;
          end
        end
        S_MEM: begin
          // A ready arriving in the final allowed cycle still completes the access.
          if (bus.mem_rdy) begin
            state_q <= is_st ? S_IF : S_WB;
          end else if (wait_d == WAIT_LIMIT) begin
            state_q <= S_HLT;
            err_q   <= 1'b1;
          end else begin
            wait_q <= wait_d;
          end
        end
        S_WB:    state_q <= S_IF;
        default: state_q <= S_HLT;
      endcase
    end
  end

  assign bus.state    = state_q;
  assign bus.num_inst = num_q;
  assign bus.halt     = !rst_i && (state_q == S_HLT);
  assign bus.err      = !rst_i && err_q;

endmodule

// File: tb/tb_mc_sequencer.sv
// Directed bench for mc_sequencer: per-cycle state/strobe expectations for each instruction class,
// memory stretch and timeout, halt request, counter wrap and reset during MEM.
module tb_mc_sequencer;
  localparam logic [6:0] OP_ADDI = 7'b0010011;
  localparam logic [6:0] OP_BR   = 7'b1100011;
  localparam logic [6:0] OP_LD   = 7'b0000011;
  localparam logic [6:0] OP_ST   = 7'b0100011;
  localparam logic [6:0] OP_JAL  = 7'b1101111;
  localparam logic [6:0] OP_JALR = 7'b1100111;
  localparam logic [6:0] OP_ILL  = 7'b0000000;

  logic clk = 1'b0;
  logic rst;
  int   checks   = 0;
  int   failures = 0;

  mc_sequencer_if #(.CNT_W(32)) ifc ();

  mc_sequencer #(.CNT_W(32), .MEM_WAIT_MAX(15)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (ifc.master)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  // Check every strobe for the current cycle, then advance one clock.
  task automatic exp_cyc(input string tag, input int st, input bit ret, input bit pcwe,
                         input logic [1:0] src, input bit rf, input bit dreq, input bit dwr);
    #1;
    chk({tag, ".state"},     32'(ifc.state),     32'(st));
    chk({tag, ".retire"},    32'(ifc.retire),    32'(ret));
    chk({tag, ".pc_we"},     32'(ifc.pc_we),     32'(pcwe));
    chk({tag, ".pc_src"},    32'(ifc.pc_src),    32'(src));
    chk({tag, ".rf_we_en"},  32'(ifc.rf_we_en),  32'(rf));
    chk({tag, ".d_mem_req"}, 32'(ifc.d_mem_req), 32'(dreq));
    chk({tag, ".d_mem_wr"},  32'(ifc.d_mem_wr),  32'(dwr));
    chk({tag, ".i_mem_req"}, 32'(ifc.i_mem_req), 32'(st == 0));
    chk({tag, ".ir_we"},     32'(ifc.ir_we),     32'(st == 0));
    chk({tag, ".halt"},      32'(ifc.halt),      32'(st == 5));
    cyc();
  endtask

  initial begin
    rst          = 1'b1;
    ifc.opcode   = OP_ADDI;
    ifc.funct3   = 3'd0;
    ifc.br_taken = 1'b0;
    ifc.halt_req = 1'b0;
    ifc.mem_rdy  = 1'b0;

    // Reset held for two cycles: strobes forced low.
    cyc();
    #1;
    chk("rst.i_mem_req", 32'(ifc.i_mem_req), 32'd0);
    chk("rst.ir_we",     32'(ifc.ir_we),     32'd0);
    chk("rst.pc_src",    32'(ifc.pc_src),    32'd0);
    chk("rst.halt",      32'(ifc.halt),      32'd0);
    chk("rst.err",       32'(ifc.err),       32'd0);
    cyc();
    rst = 1'b0;
    #1;
    chk("rel.state", 32'(ifc.state),     32'd0);
    chk("rel.imem",  32'(ifc.i_mem_req), 32'd1);
    chk("rel.num",   ifc.num_inst,       32'd0);
    chk("rel.halt",  32'(ifc.halt),      32'd0);

    // ADDI x3
    for (int i = 0; i < 3; i++) begin
      exp_cyc("addi.if", 0, 0, 0, 2'd0, 0, 0, 0);
      exp_cyc("addi.id", 1, 0, 0, 2'd0, 0, 0, 0);
      exp_cyc("addi.ex", 2, 0, 0, 2'd0, 0, 0, 0);
      exp_cyc("addi.wb", 4, 1, 1, 2'd0, 1, 0, 0);
    end
    #1 chk("addi.num", ifc.num_inst, 32'd3);

    // BEQ taken, BR_TAKEN already high in IF/ID must not leak into PC_SRC
    ifc.opcode   = OP_BR;
    ifc.br_taken = 1'b1;
    exp_cyc("beqt.if", 0, 0, 0, 2'd0, 0, 0, 0);
    exp_cyc("beqt.id", 1, 0, 0, 2'd0, 0, 0, 0);
    exp_cyc("beqt.ex", 2, 1, 1, 2'd1, 0, 0, 0);
    ifc.br_taken = 1'b0;
    exp_cyc("beqn.if", 0, 0, 0, 2'd0, 0, 0, 0);
    exp_cyc("beqn.id", 1, 0, 0, 2'd0, 0, 0, 0);
    exp_cyc("beqn.ex", 2, 1, 1, 2'd0, 0, 0, 0);
    #1 chk("beq.num", ifc.num_inst, 32'd5);

    // LW with two wait cycles
    ifc.opcode = OP_LD;
    exp_cyc("lw.if",  0, 0, 0, 2'd0, 0, 0, 0);
    exp_cyc("lw.id",  1, 0, 0, 2'd0, 0, 0, 0);
    exp_cyc("lw.ex",  2, 0, 0, 2'd0, 0, 0, 0);
    exp_cyc("lw.m1",  3, 0, 0, 2'd0, 0, 1, 0);
    exp_cyc("lw.m2",  3, 0, 0, 2'd0, 0, 1, 0);
    ifc.mem_rdy = 1'b1;
    exp_cyc("lw.m3",  3, 0, 0, 2'd0, 0, 1, 0);
    exp_cyc("lw.wb",  4, 1, 1, 2'd0, 1, 0, 0);
    #1 chk("lw.num", ifc.num_inst, 32'd6);

    // SW with immediate ready
    ifc.opcode = OP_ST;
    exp_cyc("sw.if",  0, 0, 0, 2'd0, 0, 0, 0);
    exp_cyc("sw.id",  1, 0, 0, 2'd0, 0, 0, 0);
    exp_cyc("sw.ex",  2, 0, 0, 2'd0, 0, 0, 0);
    exp_cyc("sw.mem", 3, 1, 1, 2'd0, 0, 1, 1);
    ifc.mem_rdy = 1'b0;

    // JALR, JAL, illegal
    ifc.opcode = OP_JALR;
    exp_cyc("jalr.if", 0, 0, 0, 2'd0, 0, 0, 0);
    exp_cyc("jalr.id", 1, 0, 0, 2'd0, 0, 0, 0);
    exp_cyc("jalr.ex", 2, 0, 0, 2'd0, 0, 0, 0);
    exp_cyc("jalr.wb", 4, 1, 1, 2'd2, 1, 0, 0);
    ifc.opcode = OP_JAL;
    exp_cyc("jal.if", 0, 0, 0, 2'd0, 0, 0, 0);
    exp_cyc("jal.id", 1, 0, 0, 2'd0, 0, 0, 0);
    exp_cyc("jal.ex", 2, 0, 0, 2'd0, 0, 0, 0);
    exp_cyc("jal.wb", 4, 1, 1, 2'd1, 1, 0, 0);
    ifc.opcode = OP_ILL;
    exp_cyc("ill.if", 0, 0, 0, 2'd0, 0, 0, 0);
    exp_cyc("ill.id", 1, 0, 0, 2'd0, 0, 0, 0);
    exp_cyc("ill.ex", 2, 1, 1, 2'd0, 0, 0, 0);
    #1 chk("mix.num", ifc.num_inst, 32'd10);

    // Counter wrap
    ifc.opcode = OP_ADDI;
    force dut.num_q = 32'hFFFF_FFFF;
    #1;
    release dut.num_q;
    #1 chk("wrap.pre", ifc.num_inst, 32'hFFFF_FFFF);
    exp_cyc("wrap.if", 0, 0, 0, 2'd0, 0, 0, 0);
    exp_cyc("wrap.id", 1, 0, 0, 2'd0, 0, 0, 0);
    exp_cyc("wrap.ex", 2, 0, 0, 2'd0, 0, 0, 0);
    exp_cyc("wrap.wb", 4, 1, 1, 2'd0, 1, 0, 0);
    #1 chk("wrap.num", ifc.num_inst, 32'd0);

    // Reset during MEM abandons the access immediately
    ifc.opcode = OP_LD;
    exp_cyc("rm.if", 0, 0, 0, 2'd0, 0, 0, 0);
    exp_cyc("rm.id", 1, 0, 0, 2'd0, 0, 0, 0);
    exp_cyc("rm.ex", 2, 0, 0, 2'd0, 0, 0, 0);
    exp_cyc("rm.m1", 3, 0, 0, 2'd0, 0, 1, 0);
    rst = 1'b1;
    #1;
    chk("rm.dreq",   32'(ifc.d_mem_req), 32'd0);
    chk("rm.retire", 32'(ifc.retire),    32'd0);
    chk("rm.pc_we",  32'(ifc.pc_we),     32'd0);
    cyc();
    rst = 1'b0;

    // HALT_REQ ignored in IF, honoured in ID
    ifc.opcode   = OP_ADDI;
    ifc.halt_req = 1'b1;
    exp_cyc("hr.if",  0, 0, 0, 2'd0, 0, 0, 0);
    exp_cyc("hr.id",  1, 0, 0, 2'd0, 0, 0, 0);
    ifc.halt_req = 1'b0;
    exp_cyc("hr.hlt", 5, 0, 0, 2'd0, 0, 0, 0);
    exp_cyc("hr.hl2", 5, 0, 0, 2'd0, 0, 0, 0);
    #1;
    chk("hr.num", ifc.num_inst, 32'd0);
    chk("hr.err", 32'(ifc.err), 32'd0);
    rst = 1'b1;
    #1 chk("hr.rst_halt", 32'(ifc.halt), 32'd0);
    cyc();
    rst = 1'b0;

    // One ADDI, then LW with ready in the 15th MEM cycle (no error)
    exp_cyc("b.if", 0, 0, 0, 2'd0, 0, 0, 0);
    exp_cyc("b.id", 1, 0, 0, 2'd0, 0, 0, 0);
    exp_cyc("b.ex", 2, 0, 0, 2'd0, 0, 0, 0);
    exp_cyc("b.wb", 4, 1, 1, 2'd0, 1, 0, 0);
    ifc.opcode = OP_LD;
    exp_cyc("l15.if", 0, 0, 0, 2'd0, 0, 0, 0);
    exp_cyc("l15.id", 1, 0, 0, 2'd0, 0, 0, 0);
    exp_cyc("l15.ex", 2, 0, 0, 2'd0, 0, 0, 0);
    for (int i = 0; i < 14; i++) exp_cyc("l15.mem", 3, 0, 0, 2'd0, 0, 1, 0);
    ifc.mem_rdy = 1'b1;
    exp_cyc("l15.last", 3, 0, 0, 2'd0, 0, 1, 0);
    ifc.mem_rdy = 1'b0;
    #1 chk("l15.err", 32'(ifc.err), 32'd0);
    exp_cyc("l15.wb", 4, 1, 1, 2'd0, 1, 0, 0);
    #1 chk("l15.num", ifc.num_inst, 32'd2);

    // LW timeout: 15 MEM cycles without ready -> HLT with ERR
    exp_cyc("to.if", 0, 0, 0, 2'd0, 0, 0, 0);
    exp_cyc("to.id", 1, 0, 0, 2'd0, 0, 0, 0);
    exp_cyc("to.ex", 2, 0, 0, 2'd0, 0, 0, 0);
    for (int i = 0; i < 15; i++) exp_cyc("to.mem", 3, 0, 0, 2'd0, 0, 1, 0);
    #1;
    chk("to.err", 32'(ifc.err),     32'd1);
    chk("to.num", ifc.num_inst,     32'd2);
    exp_cyc("to.hlt", 5, 0, 0, 2'd0, 0, 0, 0);
    rst = 1'b1;
    #1;
    chk("to.rst_err",  32'(ifc.err),  32'd0);
    chk("to.rst_halt", 32'(ifc.halt), 32'd0);
    cyc();
    rst = 1'b0;
    #1;
    chk("to.after_state", 32'(ifc.state), 32'd0);
    chk("to.after_err",   32'(ifc.err),   32'd0);
    chk("to.after_num",   ifc.num_inst,   32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/mc_sequencer.md
# mc_sequencer

Multi-cycle control sequencer for the RV32I core. It steps each instruction through the IF/ID/EX/MEM/WB states and gates the write strobes that the decoder produces, so the PC, IR, register file and data memory are only written in the correct state. It selects the next-PC source, stretches the MEM state until data memory is ready, and counts retired instructions. It sits between the instruction register/decoder and the PC/RF/memory enable logic.

## Interface
- CNT_W, 32, width of retired-instruction counter
- MEM_WAIT_MAX, 15, maximum MEM cycles without MEM_RDY before error halt (1..255)

- CLK  in  1  clock; all state updates on rising edge
- RST  in  1  synchronous, active-high reset
- OPCODE  in  7  IR[6:0]; stable from ID through end of instruction
- FUNCT3  in  3  IR[14:12]; carried for future use, ignored by the state machine
- BR_TAKEN  in  1  branch comparison result; valid in EX
- HALT_REQ  in  1  decoder/halt-check flag; sampled in ID
- MEM_RDY  in  1  data memory completion; sampled in MEM
- STATE  out  3  IF=0, ID=1, EX=2, MEM=3, WB=4, HLT=5
- I_MEM_REQ  out  1  instruction fetch strobe
- IR_WE  out  1  IR load enable
- PC_WE  out  1  PC load enable
- PC_SRC  out  2  0=PC+4, 1=PC+imm (branch/JAL), 2=(rs1+imm)&~1 (JALR)
- RF_WE_EN  out  1  gate ANDed with decoder RF_WE
- D_MEM_REQ  out  1  data memory access strobe
- D_MEM_WR  out  1  1=store, 0=load; meaningful only with D_MEM_REQ
- RETIRE  out  1  one-cycle pulse when an instruction completes
- NUM_INST  out  CNT_W  retired-instruction count
- HALT  out  1  sticky halt
- ERR  out  1  sticky memory-timeout flag

## Operation
- Opcode classes:
  - BR = 1100011
  - LD = 0000011
  - ST = 0100011
  - JAL = 1101111
  - JALR = 1100111
  - ALU = 0110011, 0010011, 0110111, 0010111
  - any other opcode is ILL
- IF: I_MEM_REQ=1, IR_WE=1; go to ID.
- ID: if HALT_REQ, go to HLT (no retire). Otherwise go to EX.
- EX:
  - BR: PC_WE=1, PC_SRC=BR_TAKEN?1:0, RETIRE=1; go to IF.
  - LD/ST: go to MEM, clear the wait counter.
  - ILL: PC_WE=1, PC_SRC=0, RETIRE=1, no RF write; go to IF.
  - Otherwise: go to WB.
- MEM: D_MEM_REQ=1, D_MEM_WR=(ST).
  - If MEM_RDY: ST does PC_WE=1, PC_SRC=0, RETIRE=1 and goes to IF; LD goes to WB.
  - If !MEM_RDY: increment the wait counter. When the counter reaches MEM_WAIT_MAX, drop D_MEM_REQ and go to HLT with ERR=1.
- WB: RF_WE_EN=1, PC_WE=1, RETIRE=1; go to IF. PC_SRC is 1 for JAL, 2 for JALR, 0 otherwise.
- HLT: all strobes 0, HALT=1. Only RST leaves HLT.
- NUM_INST increments on every RETIRE cycle (visible next cycle) and wraps to 0 after all-ones.
- Output types: all outputs are Moore (decoded from STATE/OPCODE) except PC_SRC and PC_WE/RETIRE in EX/MEM, which also depend on BR_TAKEN/MEM_RDY.

## Timing
- Reset:
  - While RST=1: all strobes (I_MEM_REQ, IR_WE, PC_WE, RF_WE_EN, D_MEM_REQ, D_MEM_WR, RETIRE) are forced to 0 combinationally, PC_SRC=0, HALT=0, ERR=0.
  - On the next edge: STATE=IF, NUM_INST=0, wait counter=0.
  - The first cycle after RST deasserts is IF with I_MEM_REQ=1.
- Reset mid-MEM abandons the access: D_MEM_REQ drops in the same cycle RST is seen. Reset in HLT clears HALT and ERR.
- Latency with zero memory wait:
  - ALU/JAL/JALR: 4 cycles (IF,ID,EX,WB)
  - BR: 3 cycles
  - ST: 4 cycles
  - LD: 5 cycles
  - Each MEM cycle without MEM_RDY adds 1 cycle.
- MEM_RDY in the first MEM cycle counts as zero wait. ERR fires after exactly MEM_WAIT_MAX consecutive MEM cycles without MEM_RDY; MEM_RDY arriving in that same cycle wins (no error).
- RETIRE is never asserted in IF, ID or HLT. There is exactly one RETIRE per non-halting instruction.
- HALT_REQ is ignored outside ID. BR_TAKEN is ignored outside EX.

## Test plan
- Reset → RST=1 for 2 cycles, then 0 → STATE=0, I_MEM_REQ=1, NUM_INST=0, HALT=0 on the first cycle after release.
- ADDI (OPCODE=0010011) back-to-back ×3 → states 0,1,2,4 repeating; RETIRE every 4th cycle; RF_WE_EN only in WB; NUM_INST=3 afterwards.
- BEQ with BR_TAKEN=1, then with BR_TAKEN=0 → each takes 3 cycles; EX shows PC_WE=1 with PC_SRC=1, then PC_SRC=0; RF_WE_EN never 1.
- LW with MEM_RDY low for 2 MEM cycles, then high → D_MEM_REQ=1 and D_MEM_WR=0 for 3 cycles, then WB; 7 cycles total. SW with MEM_RDY=1 immediately → 4 cycles, D_MEM_WR=1.
- LW with MEM_RDY held 0, MEM_WAIT_MAX=15 → after 15 MEM cycles: STATE=5, ERR=1, HALT=1, D_MEM_REQ=0, NUM_INST unchanged. RST then clears HALT and ERR.
- Boundary cases:
  - JALR → WB with PC_SRC=2.
  - HALT_REQ=1 in ID → STATE=5 next cycle, no RETIRE.
  - NUM_INST preloaded (via a force) to 0xFFFFFFFF, then one retire → NUM_INST=0.
  - RST asserted during MEM → D_MEM_REQ=0 in that same cycle.
